alu_issue_arbiter: RTL and testbench

- Sequencer and round-robin arbiter that shares one combinational alu16 instance between N_REQ requesters.
- Each requester presents an operation with a valid/ready handshake. The block registers the operands, drives alu16, captures y and flags_raw, and returns a one-cycle response to the granted requester.
- Owns the 5-bit processor status register (PSR) with flag order {C,F,Z,L,N}, and feeds PSR C back as the ALU carry-in.
- Sits between the decode/control logic and alu16, replacing the static switch hookup used at board level.

---
 rtl/alu_issue_arbiter_pkg.sv | 30 +++
 rtl/alu_issue_arbiter_rr_arbiter.sv | 33 +++
 rtl/alu_issue_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_issue_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_arbiter_pkg.sv
// Shared definitions for the alu16 issue arbiter: opcodes, PSR flag positions
// and the sequencer state encoding.
package alu_issue_arbiter_pkg;

    localparam int OPW    = 5;
    localparam int NFLAGS = 5;

    localparam logic [OPW-1:0] OP_ADD = 5'd0;
    localparam logic [OPW-1:0] OP_SUB = 5'd8;
    localparam logic [OPW-1:0] OP_CMP = 5'd10;
    localparam logic [OPW-1:0] OP_AND = 5'd14;
    localparam logic [OPW-1:0] OP_OR  = 5'd16;
    localparam logic [OPW-1:0] OP_XOR = 5'd18;
    localparam logic [OPW-1:0] OP_NOT = 5'd20;
    localparam logic [OPW-1:0] OP_LSH = 5'd21;

    // PSR bit positions, order {C,F,Z,L,N}
    localparam int FLAG_C = 4;
    localparam int FLAG_F = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_N = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first valid index searching upward from
// last+1, wrapping modulo N_REQ.
module rr_arbiter
    import alu_issue_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int IW    = 1
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] grant,
    output logic [IW-1:0]    idx
);

    always_comb begin
        int  cand;
        logic found;
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        grant = '0;
        idx   = '0;
        cand  = 0;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = (int'(last) + i) % N_REQ;
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_issue_arbiter.sv
// Three-state sequencer sharing one alu16 between N_REQ requesters; owns the
// PSR and feeds its carry bit back to the ALU.
module alu_issue_arbiter
    import alu_issue_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W     = 16
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*OPW-1:0]    req_op,
    input  logic [N_REQ*W-1:0]      req_a,
    input  logic [N_REQ*W-1:0]      req_b,
    input  logic [N_REQ*5-1:0]      req_shamt,
    input  logic [N_REQ*NFLAGS-1:0] req_flags_sel,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [W-1:0]            rsp_y,
    output logic                    rsp_wr,
    output logic [NFLAGS-1:0]       rsp_flags,
    output logic [NFLAGS-1:0]       psr,
    output logic                    busy,
    output logic [W-1:0]            alu_a,
    output logic [W-1:0]            alu_b,
    output logic [OPW-1:0]          alu_op,
    output logic [4:0]              alu_shamt,
    output logic                    alu_c_in,
    input  logic [W-1:0]            alu_y,
    input  logic                    alu_y_valid,
    input  logic [NFLAGS-1:0]       alu_flags_raw
);

    localparam int IW = (N_REQ > 2) ? 2 : 1;

    state_e              state_q, state_d;
    logic [IW-1:0]       rr_last_q, owner_q, win_idx;
    logic [N_REQ-1:0]    win_grant;
    logic                accept, exec_commit;

    logic [OPW-1:0]      op_q;
    logic [W-1:0]        a_q, b_q;
    logic [4:0]          shamt_q;
    logic [NFLAGS-1:0]   sel_q;
    logic [W-1:0]        rsp_y_q;
    logic                rsp_wr_q;
    logic [NFLAGS-1:0]   rsp_flags_q;
    logic [NFLAGS-1:0]   psr_q;

    rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr_arbiter (
        .valid (req_valid),
        .last  (rr_last_q),
        .grant (win_grant),
        .idx   (win_idx)
    );

    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        exec_commit = 1'b0;
        case (state_q)
            ST_IDLE: if (!flush && |req_valid) begin
                accept  = 1'b1;
                state_d = ST_EXEC;
            end
            ST_EXEC: if (flush) begin
                state_d = ST_IDLE;
            end else begin
                exec_commit = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Operand registers keep driving alu16 between operations.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            shamt_q   <= '0;
            sel_q     <= '0;
            owner_q   <= '0;
            rr_last_q <= IW'(N_REQ - 1);
        end else if (accept) begin
            op_q      <= req_op[int'(win_idx)*OPW +: OPW];
            a_q       <= req_a[int'(win_idx)*W +: W];
            b_q       <= req_b[int'(win_idx)*W +: W];
            shamt_q   <= req_shamt[int'(win_idx)*5 +: 5];
            sel_q     <= req_flags_sel[int'(win_idx)*NFLAGS +: NFLAGS];
            owner_q   <= win_idx;
            rr_last_q <= win_idx;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rsp_y_q     <= '0;
            rsp_wr_q    <= 1'b0;
            rsp_flags_q <= '0;
            psr_q       <= '0;
        end else if (exec_commit) begin
            rsp_y_q     <= alu_y;
            rsp_wr_q    <= alu_y_valid;
            rsp_flags_q <= alu_flags_raw;
            psr_q       <= (psr_q & ~sel_q) | (alu_flags_raw & sel_q);
        end
    end

    // Grant is gated by reset so no lane sees ready while the block is held.
    assign req_ready = (accept && !reset) ? win_grant : '0;

    always_comb begin
        rsp_valid = '0;
        if (state_q == ST_RESP && !flush) rsp_valid[owner_q] = 1'b1;
    end

    assign busy      = (state_q != ST_IDLE);
    assign rsp_y     = rsp_y_q;
    assign rsp_wr    = rsp_wr_q;
    assign rsp_flags = rsp_flags_q;
    assign psr       = psr_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign alu_op    = op_q;
    assign alu_shamt = shamt_q;
    assign alu_c_in  = psr_q[FLAG_C];

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Self-checking bench for alu_issue_arbiter with a behavioural alu16 stand-in
// and a transaction-level reference model.
module tb_alu_issue_arbiter;
    import alu_issue_arbiter_pkg::*;

    localparam int N = 2;

    logic            CLOCK_50 = 1'b0;
    logic            reset, flush;
    logic [N-1:0]    req_valid, req_ready, rsp_valid;
    logic [N*5-1:0]  req_op, req_shamt, req_flags_sel;
    logic [N*16-1:0] req_a, req_b;
    logic [15:0]     rsp_y, alu_a, alu_b, alu_y;
    logic            rsp_wr, busy, alu_c_in, alu_y_valid;
    logic [4:0]      rsp_flags, psr, alu_op, alu_shamt, alu_flags_raw;

    logic [4:0]  op_l[N];
    logic [15:0] a_l[N], b_l[N];
    logic [4:0]  sh_l[N], sel_l[N];

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [4:0]  psr_m;
    int          last_m;
    logic [15:0] y_m;
    logic        wr_m;
    logic [4:0]  fl_m;

    alu_issue_arbiter #(.N_REQ(N), .W(16)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
        .req_flags_sel(req_flags_sel), .rsp_valid(rsp_valid), .rsp_y(rsp_y),
        .rsp_wr(rsp_wr), .rsp_flags(rsp_flags), .psr(psr), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_shamt(alu_shamt),
        .alu_c_in(alu_c_in), .alu_y(alu_y), .alu_y_valid(alu_y_valid),
        .alu_flags_raw(alu_flags_raw)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [21:0] alu_model(input logic [4:0] op, input logic [15:0] a,
                                              input logic [15:0] b, input logic [4:0] sh,
                                              input logic cin);
        logic [16:0] s;
        logic [15:0] y;
        logic wr, c, f;
        s = '0; y = '0; wr = 1'b1; c = 1'b0; f = 1'b0;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b} + {16'd0, cin};
                y = s[15:0]; c = s[16];
                f = (a[15] == b[15]) && (y[15] != a[15]);
            end
            OP_SUB, OP_CMP: begin
                s = {1'b0, a} + {1'b0, ~b} + 17'd1;
                y = s[15:0]; c = s[16];
                f = (a[15] != b[15]) && (y[15] != a[15]);
                wr = (op != OP_CMP);
            end
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOT: y = ~a;
            OP_LSH: y = a << sh;
            default: y = ~b;
        endcase
        return {wr, y, c, f, (y == 16'd0), ($signed(a) < $signed(b)), y[15]};
    endfunction

    always_comb {alu_y_valid, alu_y, alu_flags_raw} = alu_model(alu_op, alu_a, alu_b, alu_shamt, alu_c_in);

    always_comb begin
        req_op = '0; req_a = '0; req_b = '0; req_shamt = '0; req_flags_sel = '0;
        for (int i = 0; i < N; i++) begin
            req_op[i*5 +: 5]        = op_l[i];
            req_a[i*16 +: 16]       = a_l[i];
            req_b[i*16 +: 16]       = b_l[i];
            req_shamt[i*5 +: 5]     = sh_l[i];
            req_flags_sel[i*5 +: 5] = sel_l[i];
        end
    end

    function automatic int winner(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int l);
        logic [N-1:0] o;
        o = '0;
        o[l] = 1'b1;
        return o;
    endfunction

    // Applies the spec rules for one completed operation from lane l.
    task automatic model_commit(input int l);
        {wr_m, y_m, fl_m} = alu_model(op_l[l], a_l[l], b_l[l], sh_l[l], psr_m[FLAG_C]);
        psr_m  = (psr_m & ~sel_l[l]) | (fl_m & sel_l[l]);
        last_m = l;
    endtask

    task automatic set_lane(input int l, input logic [4:0] op, input logic [15:0] a,
                            input logic [15:0] b, input logic [4:0] sh, input logic [4:0] sel);
        op_l[l] = op; a_l[l] = a; b_l[l] = b; sh_l[l] = sh; sel_l[l] = sel;
    endtask

    // One full accept/exec/resp sequence; returns observations only.
    task automatic issue_op(input logic [N-1:0] mask, output logic [N-1:0] g_ready,
                            output logic g_busy, output logic g_cin, output logic [15:0] g_alu_a,
                            output logic [N-1:0] g_rspv, output logic [15:0] g_y,
                            output logic g_wr, output logic [4:0] g_flags, output logic [4:0] g_psr);
        @(negedge CLOCK_50); req_valid = mask; #1 g_ready = req_ready;
        @(negedge CLOCK_50); req_valid = '0;  #1 g_busy = busy; g_cin = alu_c_in; g_alu_a = alu_a;
        @(negedge CLOCK_50); #1 g_rspv = rsp_valid; g_y = rsp_y; g_wr = rsp_wr; g_flags = rsp_flags; g_psr = psr;
    endtask

    logic [N-1:0] g_ready, g_rspv;
    logic         g_busy, g_cin, g_wr;
    logic [15:0]  g_alu_a, g_y;
    logic [4:0]   g_flags, g_psr;

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; req_valid = '0;
        for (int i = 0; i < N; i++) set_lane(i, OP_ADD, 16'h1234, 16'h4321, 5'd0, 5'h1f);
        psr_m = '0; last_m = N - 1; y_m = '0; wr_m = 1'b0; fl_m = '0;
        repeat (2) @(negedge CLOCK_50);
        req_valid = '1; #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready got=%b exp=0", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (psr !== 5'd0) begin errors++; $display("FAIL reset_psr got=%b exp=0", psr); end
        checks++; if ({rsp_y, rsp_wr, rsp_flags} !== 22'd0) begin errors++; $display("FAIL reset_rsp got=%h/%b/%b exp=0", rsp_y, rsp_wr, rsp_flags); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if ({alu_a, alu_b, alu_op, alu_shamt} !== 42'd0) begin errors++; $display("FAIL reset_alu got=%h %h %h %h exp=0", alu_a, alu_b, alu_op, alu_shamt); end
        req_valid = '0;
        @(negedge CLOCK_50); reset = 1'b0;
    endtask

    task automatic test_single_add();
        set_lane(0, OP_ADD, 16'h0005, 16'h0010, 5'd0, 5'b11111);
        model_commit(0);
        issue_op(2'b01, g_ready, g_busy, g_cin, g_alu_a, g_rspv, g_y, g_wr, g_flags, g_psr);
        checks++; if (g_ready !== 2'b01) begin errors++; $display("FAIL add_ready got=%b exp=01", g_ready); end
        checks++; if (g_busy !== 1'b1 || g_alu_a !== 16'h0005) begin errors++; $display("FAIL add_exec got busy=%b a=%h exp busy=1 a=0005", g_busy, g_alu_a); end
        checks++; if (g_rspv !== 2'b01) begin errors++; $display("FAIL add_rsp_valid got=%b exp=01", g_rspv); end
        checks++; if (g_y !== 16'h0015 || g_wr !== 1'b1) begin errors++; $display("FAIL add_y got=%h wr=%b exp=0015 wr=1", g_y, g_wr); end
        checks++; if (g_psr !== g_flags || g_psr !== psr_m || g_psr[FLAG_Z] !== 1'b0) begin errors++; $display("FAIL add_psr got psr=%b flags=%b exp=%b", g_psr, g_flags, psr_m); end
        @(negedge CLOCK_50); #1;
        checks++; if (rsp_valid !== '0 || busy !== 1'b0) begin errors++; $display("FAIL add_idle got rsp_valid=%b busy=%b exp 0 0", rsp_valid, busy); end
    endtask

    task automatic test_alternating();
        int w;
        set_lane(0, OP_OR,  16'h00f0, 16'h0f00, 5'd0, 5'b00101);
        set_lane(1, OP_SUB, 16'h0100, 16'h0001, 5'd0, 5'b10011);
        @(negedge CLOCK_50);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            w = winner(2'b11, last_m);
            #1;
            checks++; if (req_ready !== onehot(w)) begin errors++; $display("FAIL rr_grant%0d got=%b exp=%b", k, req_ready, onehot(w)); end
            model_commit(w);
            @(negedge CLOCK_50); a_l[0] = 16'($urandom); #1;
            checks++; if (req_ready !== '0 || busy !== 1'b1) begin errors++; $display("FAIL rr_exec%0d got ready=%b busy=%b exp 00 1", k, req_ready, busy); end
            @(negedge CLOCK_50); #1;
            checks++; if (rsp_valid !== onehot(w) || rsp_y !== y_m || psr !== psr_m) begin errors++; $display("FAIL rr_rsp%0d got v=%b y=%h psr=%b exp v=%b y=%h psr=%b", k, rsp_valid, rsp_y, psr, onehot(w), y_m, psr_m); end
            @(negedge CLOCK_50);
        end
        req_valid = '0;
    endtask

    task automatic test_cmp_sel();
        logic [4:0] prev;
        prev = psr_m;
        set_lane(1, OP_CMP, 16'h0010, 16'h0010, 5'd0, 5'b00100);
        model_commit(1);
        issue_op(2'b10, g_ready, g_busy, g_cin, g_alu_a, g_rspv, g_y, g_wr, g_flags, g_psr);
        checks++; if (g_ready !== 2'b10 || g_rspv !== 2'b10) begin errors++; $display("FAIL cmp_lane got ready=%b rsp=%b exp 10 10", g_ready, g_rspv); end
        checks++; if (g_wr !== 1'b0) begin errors++; $display("FAIL cmp_wr got=%b exp=0", g_wr); end
        checks++; if (g_psr !== {prev[4:3], 1'b1, prev[1:0]}) begin errors++; $display("FAIL cmp_psr got=%b exp=%b", g_psr, {prev[4:3], 1'b1, prev[1:0]}); end
        prev = psr_m;
        set_lane(0, OP_XOR, 16'($urandom), 16'($urandom), 5'd0, 5'b00000);
        model_commit(0);
        issue_op(2'b01, g_ready, g_busy, g_cin, g_alu_a, g_rspv, g_y, g_wr, g_flags, g_psr);
        checks++; if (g_psr !== prev) begin errors++; $display("FAIL sel0_psr got=%b exp=%b", g_psr, prev); end
        checks++; if (g_y !== y_m || g_flags !== fl_m) begin errors++; $display("FAIL sel0_y got=%h/%b exp=%h/%b", g_y, g_flags, y_m, fl_m); end
    endtask

    task automatic test_carry_chain();
        set_lane(0, OP_ADD, 16'hffff, 16'h0001, 5'd0, 5'b10000);
        model_commit(0);
        issue_op(2'b01, g_ready, g_busy, g_cin, g_alu_a, g_rspv, g_y, g_wr, g_flags, g_psr);
        checks++; if (g_psr[FLAG_C] !== 1'b1 || g_psr !== psr_m) begin errors++; $display("FAIL carry_set got=%b exp=%b", g_psr, psr_m); end
        set_lane(1, OP_ADD, 16'h0001, 16'h0001, 5'd0, 5'b00000);
        model_commit(1);
        issue_op(2'b10, g_ready, g_busy, g_cin, g_alu_a, g_rspv, g_y, g_wr, g_flags, g_psr);
        checks++; if (g_cin !== 1'b1) begin errors++; $display("FAIL carry_cin got=%b exp=1", g_cin); end
        checks++; if (g_y !== 16'h0003) begin errors++; $display("FAIL carry_y got=%h exp=0003", g_y); end
    endtask

    task automatic test_flush();
        // flush in IDLE blocks the grant
        set_lane(0, OP_AND, 16'hff0f, 16'h0ff0, 5'd0, 5'b11111);
        set_lane(1, OP_NOT, 16'h00ff, 16'h0000, 5'd0, 5'b11111);
        @(negedge CLOCK_50); flush = 1'b1; req_valid = 2'b01; #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL flush_idle_ready got=%b exp=00", req_ready); end
        @(negedge CLOCK_50); req_valid = '0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_idle_busy got=%b exp=0", busy); end
        // flush in EXEC aborts; pending lane 1 is granted right after
        flush = 1'b0; req_valid = 2'b01; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL flush_exec_accept got=%b exp=01", req_ready); end
        last_m = 0;
        @(negedge CLOCK_50); flush = 1'b1; req_valid = 2'b10; #1;
        checks++; if (busy !== 1'b1 || req_ready !== '0) begin errors++; $display("FAIL flush_exec_state got busy=%b ready=%b exp 1 00", busy, req_ready); end
        @(negedge CLOCK_50); flush = 1'b0; #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== '0) begin errors++; $display("FAIL flush_exec_idle got busy=%b v=%b exp 0 00", busy, rsp_valid); end
        checks++; if (psr !== psr_m || rsp_y !== y_m) begin errors++; $display("FAIL flush_exec_hold got psr=%b y=%h exp %b %h", psr, rsp_y, psr_m, y_m); end
        checks++; if (req_ready !== onehot(winner(2'b10, last_m))) begin errors++; $display("FAIL flush_pending got=%b exp=10", req_ready); end
        model_commit(1);
        @(negedge CLOCK_50); req_valid = '0;
        @(negedge CLOCK_50); #1;
        checks++; if (rsp_valid !== 2'b10 || rsp_y !== y_m) begin errors++; $display("FAIL flush_pending_rsp got v=%b y=%h exp 10 %h", rsp_valid, rsp_y, y_m); end
        // flush in RESP suppresses the pulse but the PSR update stands
        @(negedge CLOCK_50); req_valid = 2'b01; model_commit(0);
        @(negedge CLOCK_50); req_valid = '0;
        @(negedge CLOCK_50); flush = 1'b1; #1;
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL flush_resp_valid got=%b exp=00", rsp_valid); end
        checks++; if (psr !== psr_m || rsp_y !== y_m) begin errors++; $display("FAIL flush_resp_psr got psr=%b y=%h exp %b %h", psr, rsp_y, psr_m, y_m); end
        @(negedge CLOCK_50); flush = 1'b0; #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_resp_idle got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid();
        set_lane(0, OP_SUB, 16'h0003, 16'h0009, 5'd0, 5'b11111);
        set_lane(1, OP_OR,  16'h1200, 16'h0034, 5'd0, 5'b11111);
        @(negedge CLOCK_50); req_valid = 2'b01;
        @(negedge CLOCK_50); req_valid = 2'b11;
        #2 reset = 1'b1;
        #1;
        psr_m = '0; last_m = N - 1; y_m = '0; wr_m = 1'b0; fl_m = '0;
        checks++; if (busy !== 1'b0 || psr !== 5'd0 || alu_c_in !== 1'b0) begin errors++; $display("FAIL rstmid_state got busy=%b psr=%b cin=%b exp 0 0 0", busy, psr, alu_c_in); end
        checks++; if ({rsp_y, rsp_wr, rsp_flags} !== 22'd0 || {alu_a, alu_b, alu_op, alu_shamt} !== 42'd0) begin errors++; $display("FAIL rstmid_regs got y=%h a=%h b=%h op=%h exp 0", rsp_y, alu_a, alu_b, alu_op); end
        checks++; if (req_ready !== '0 || rsp_valid !== '0) begin errors++; $display("FAIL rstmid_hs got ready=%b v=%b exp 00 00", req_ready, rsp_valid); end
        @(negedge CLOCK_50); reset = 1'b0; #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rstmid_first_grant got=%b exp=01", req_ready); end
        model_commit(0);
        @(negedge CLOCK_50); req_valid = '0;
        @(negedge CLOCK_50); #1;
        checks++; if (rsp_valid !== 2'b01 || rsp_y !== y_m || psr !== psr_m) begin errors++; $display("FAIL rstmid_rsp got v=%b y=%h psr=%b exp 01 %h %b", rsp_valid, rsp_y, psr, y_m, psr_m); end
    endtask

    task automatic test_random();
        logic [4:0] ops[9];
        logic [N-1:0] mask;
        int w;
        ops = '{OP_ADD, OP_SUB, OP_CMP, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSH, 5'd31};
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < N; i++)
                set_lane(i, ops[$urandom_range(8, 0)], 16'($urandom), 16'($urandom),
                         5'($urandom_range(15, 0)), 5'($urandom));
            mask = N'($urandom_range(3, 1));
            w = winner(mask, last_m);
            model_commit(w);
            issue_op(mask, g_ready, g_busy, g_cin, g_alu_a, g_rspv, g_y, g_wr, g_flags, g_psr);
            checks++; if (g_ready !== onehot(w) || g_rspv !== onehot(w)) begin errors++; $display("FAIL rand%0d_lane got ready=%b rsp=%b exp %b", n, g_ready, g_rspv, onehot(w)); end
            checks++; if (g_alu_a !== a_l[w]) begin errors++; $display("FAIL rand%0d_alu_a got=%h exp=%h", n, g_alu_a, a_l[w]); end
            checks++; if (g_y !== y_m || g_wr !== wr_m || g_flags !== fl_m) begin errors++; $display("FAIL rand%0d_rsp got %h/%b/%b exp %h/%b/%b", n, g_y, g_wr, g_flags, y_m, wr_m, fl_m); end
            checks++; if (g_psr !== psr_m) begin errors++; $display("FAIL rand%0d_psr got=%b exp=%b", n, g_psr, psr_m); end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_alternating();
        test_cmp_sel();
        test_carry_chain();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
